// File: rtl/dmem_chk_pkg.sv
// ----------------------------------------------------------------------------
// dmem_chk_pkg: shared state encoding and defaults for the dmem store checker. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package dmem_chk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } chk_state_e;

  localparam logic [31:0] DEF_PASS_ADDR  = 32'd100;
  localparam logic [31:0] DEF_PASS_DATA  = 32'd7;
  localparam logic [31:0] DEF_ALLOW_ADDR = 32'd96;

  // One log entry is {address, data}.
  localparam int LOG_ENTRY_W = 64;

  function automatic logic is_verdict(chk_state_e s);
    return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_store_log.sv
// ----------------------------------------------------------------------------
// dmem_store_log: circular store log with saturating fill count and newest-first read. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dmem_store_log
  import dmem_chk_pkg::*;
#(
  parameter int LOG_AW = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   wr_en,
  input  logic [LOG_ENTRY_W-1:0] wr_entry,
  input  logic [LOG_AW-1:0]      rd_idx,
  output logic [LOG_ENTRY_W-1:0] rd_entry,
  output logic [LOG_AW:0]        count
);

  localparam int              DEPTH = 1 << LOG_AW;
  localparam logic [LOG_AW:0] FULL  = (LOG_AW + 1)'(DEPTH);

  logic [LOG_ENTRY_W-1:0] mem_q [DEPTH];
  logic [LOG_AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [LOG_AW:0]        count_q, count_d;
  logic [LOG_AW-1:0]      rd_slot;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (count_q != FULL) count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is left unreset; count_q alone decides which slots are valid.
  always_ff @(posedge clk) begin
    if (wr_en && !clear) mem_q[wr_ptr_q] <= wr_entry;
  end

  always_comb begin
    rd_slot  = wr_ptr_q - 1'b1 - rd_idx;
    rd_entry = ({1'b0, rd_idx} < count_q) ? mem_q[rd_slot] : '0;
  end

  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/dmem_store_checker.sv
// ----------------------------------------------------------------------------
// dmem_store_checker: judges the core's dmem store stream as PASS, FAIL or TIMEOUT. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dmem_store_checker
  import dmem_chk_pkg::*;
#(
  parameter logic [31:0] PASS_ADDR      = DEF_PASS_ADDR,
  parameter logic [31:0] PASS_DATA      = DEF_PASS_DATA,
  parameter logic [31:0] ALLOW_ADDR     = DEF_ALLOW_ADDR,
  parameter int          TIMEOUT_CYCLES = 4096,
  parameter int          CNT_W          = 16,
  parameter int          LOG_AW         = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              clear,
  input  logic              MemWrite,
  input  logic [31:0]       DataAdr,
  input  logic [31:0]       WriteData,
  input  logic [LOG_AW-1:0] log_idx,
  output logic [31:0]       log_addr,
  output logic [31:0]       log_data,
  output logic [LOG_AW:0]   log_count,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [CNT_W-1:0]  store_count,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [31:0]       fail_addr,
  output logic [31:0]       fail_data
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  chk_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0]       store_cnt_q, store_cnt_d;
  logic [31:0]            fail_addr_q, fail_addr_d;
  logic [31:0]            fail_data_q, fail_data_d;
  logic                   log_wr;
  logic [LOG_ENTRY_W-1:0] log_entry;

  always_comb begin
    state_d     = state_q;
    cycle_cnt_d = cycle_cnt_q;
    store_cnt_d = store_cnt_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    log_wr      = 1'b0;
    if (clear) begin
      state_d     = ST_IDLE;
      cycle_cnt_d = '0;
      store_cnt_d = '0;
      fail_addr_d = '0;
      fail_data_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: if (arm) state_d = ST_ARMED;
        ST_ARMED: begin
          if (cycle_cnt_q != '1) cycle_cnt_d = cycle_cnt_q + 1'b1;
          if (MemWrite) begin
            log_wr = 1'b1;
            if (store_cnt_q != '1) store_cnt_d = store_cnt_q + 1'b1;
            if (DataAdr == PASS_ADDR && WriteData == PASS_DATA) begin
              state_d = ST_PASS;
            end else if (DataAdr != ALLOW_ADDR) begin
              state_d     = ST_FAIL;
              fail_addr_d = DataAdr;
              fail_data_d = WriteData;
            end
          end
          // A store verdict in the final cycle takes precedence over timeout.
          if (state_d == ST_ARMED && cycle_cnt_q == TIMEOUT_LAST) state_d = ST_TIMEOUT;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cycle_cnt_q <= '0;
      store_cnt_q <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      store_cnt_q <= store_cnt_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
    end
  end

  dmem_store_log #(
    .LOG_AW (LOG_AW)
  ) u_log (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .wr_en    (log_wr),
    .wr_entry ({DataAdr, WriteData}),
    .rd_idx   (log_idx),
    .rd_entry (log_entry),
    .count    (log_count)
  );

  assign log_addr    = log_entry[LOG_ENTRY_W-1:32];
  assign log_data    = log_entry[31:0];
  assign busy        = (state_q == ST_ARMED);
  assign done        = is_verdict(state_q);
  assign pass        = (state_q == ST_PASS);
  assign fail        = (state_q == ST_FAIL);
  assign timeout     = (state_q == ST_TIMEOUT);
  assign store_count = store_cnt_q;
  assign cycle_count = cycle_cnt_q;
  assign fail_addr   = fail_addr_q;
  assign fail_data   = fail_data_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_store_checker.sv
// ----------------------------------------------------------------------------
// tb_dmem_store_checker: randomized and directed scoreboard bench for dmem_store_checker. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_dmem_store_checker;

  localparam int TO    = 16;
  localparam int LAW   = 2;
  localparam int DEPTH = 4;
  localparam int CW    = 16;
  localparam int CMAX  = 65535;

  // Reference-model verdicts
  localparam int S_IDLE = 0, S_ARMED = 1, S_PASS = 2, S_FAIL = 3, S_TO = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           arm = 1'b0;
  logic           clear = 1'b0;
  logic           MemWrite = 1'b0;
  logic [31:0]    DataAdr = '0;
  logic [31:0]    WriteData = '0;
  logic [LAW-1:0] log_idx = '0;
  logic [31:0]    log_addr, log_data, fail_addr, fail_data;
  logic [LAW:0]   log_count;
  logic           busy, done, pass, fail, timeout;
  logic [CW-1:0]  store_count, cycle_count;

  dmem_store_checker #(
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (CW),
    .LOG_AW         (LAW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .arm         (arm),
    .clear       (clear),
    .MemWrite    (MemWrite),
    .DataAdr     (DataAdr),
    .WriteData   (WriteData),
    .log_idx     (log_idx),
    .log_addr    (log_addr),
    .log_data    (log_data),
    .log_count   (log_count),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .fail        (fail),
    .timeout     (timeout),
    .store_count (store_count),
    .cycle_count (cycle_count),
    .fail_addr   (fail_addr),
    .fail_data   (fail_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          st;
    int unsigned sc;
    int unsigned cc;
    logic [31:0] fa;
    logic [31:0] fd;
    logic [1:0]  idx;
    logic [31:0] la;
    logic [31:0] ld;
    int          lc;
  } exp_t;

  int          m_st = S_IDLE;
  int unsigned m_sc = 0, m_cc = 0;
  logic [31:0] m_fa = '0, m_fd = '0;
  logic [63:0] m_log[$];          // newest entry at index 0
  exp_t        sb[$];
  int          n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic compare(input exp_t e);
    chk("busy",        32'(busy),        32'(e.st == S_ARMED));
    chk("done",        32'(done),        32'(e.st >= S_PASS));
    chk("pass",        32'(pass),        32'(e.st == S_PASS));
    chk("fail",        32'(fail),        32'(e.st == S_FAIL));
    chk("timeout",     32'(timeout),     32'(e.st == S_TO));
    chk("store_count", 32'(store_count), e.sc);
    chk("cycle_count", 32'(cycle_count), e.cc);
    chk("fail_addr",   fail_addr,        e.fa);
    chk("fail_data",   fail_data,        e.fd);
    chk("log_count",   32'(log_count),   32'(e.lc));
    chk("log_addr",    log_addr,         e.la);
    chk("log_data",    log_data,         e.ld);
  endtask

  function automatic exp_t snap(input logic [1:0] idx);
    exp_t e;
    e.st = m_st; e.sc = m_sc; e.cc = m_cc; e.fa = m_fa; e.fd = m_fd;
    e.idx = idx; e.lc = m_log.size();
    if (int'(idx) < m_log.size()) {e.la, e.ld} = m_log[idx];
    else begin e.la = '0; e.ld = '0; end
    return e;
  endfunction

  task automatic model_reset();
    m_st = S_IDLE; m_sc = 0; m_cc = 0; m_fa = '0; m_fd = '0;
    m_log.delete();
  endtask

  task automatic model_edge(input bit a, input bit c, input bit mw,
                            input logic [31:0] adr, input logic [31:0] dat);
    int unsigned prev;
    prev = m_cc;
    if (c) model_reset();
    else if (m_st == S_IDLE) begin
      if (a) m_st = S_ARMED;
    end else if (m_st == S_ARMED) begin
      if (m_cc < CMAX) m_cc++;
      if (mw) begin
        m_log.push_front({adr, dat});
        if (m_log.size() > DEPTH) void'(m_log.pop_back());
        if (m_sc < CMAX) m_sc++;
        if (adr == 32'd100 && dat == 32'd7) m_st = S_PASS;
        else if (adr != 32'd96) begin m_st = S_FAIL; m_fa = adr; m_fd = dat; end
      end
      if (m_st == S_ARMED && prev == TO - 1) m_st = S_TO;
    end
  endtask

  // One clock: drive, let the edge happen, update model, queue expectation.
  task automatic step(input bit a, input bit c, input bit mw,
                      input logic [31:0] adr, input logic [31:0] dat, input int idx);
    logic [1:0] ri;
    arm = a; clear = c; MemWrite = mw; DataAdr = adr; WriteData = dat;
    @(posedge clk);
    #1;
    model_edge(a, c, mw, adr, dat);
    ri = (idx < 0) ? 2'($urandom_range(0, 3)) : 2'(idx);
    sb.push_back(snap(ri));
    arm = 1'b0; clear = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 32'd0, 32'd0, -1);
  endtask

  // Monitor: the DUT presents registered status every cycle; check on falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        log_idx = e.idx;
        #1;
        compare(e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int r;
    logic [31:0] adr, dat;
    // Reset state
    #1;
    log_idx = '0;
    compare(snap(2'd0));
    #11 reset = 1'b1;

    // Pass flow
    step(1, 0, 0, 0, 0, -1);
    step(0, 0, 1, 32'd96, 32'd5, -1);
    step(0, 0, 1, 32'd96, 32'd3, -1);
    step(0, 0, 1, 32'd100, 32'd7, 0);
    idle(1); sb[$].idx = 2'd2; sb[$] = snap(2'd2);
    step(0, 1, 0, 0, 0, -1);

    // Illegal address, then sticky FAIL
    step(1, 0, 0, 0, 0, -1);
    step(0, 0, 1, 32'd96, 32'd1, -1);
    step(0, 0, 1, 32'd104, 32'd9, 0);
    step(0, 0, 1, 32'd100, 32'd7, 0);
    step(1, 0, 0, 0, 0, -1);
    step(0, 1, 0, 0, 0, -1);

    // Wrong data at the pass address
    step(1, 0, 0, 0, 0, -1);
    step(0, 0, 1, 32'd100, 32'd8, 0);
    step(0, 1, 0, 0, 0, -1);

    // Timeout after TO idle armed cycles
    step(1, 0, 0, 0, 0, -1);
    idle(TO + 2);
    step(0, 1, 0, 0, 0, -1);

    // Store on the last armed cycle beats timeout
    step(1, 0, 0, 0, 0, -1);
    idle(TO - 1);
    step(0, 0, 1, 32'd100, 32'd7, 0);
    idle(2);
    step(0, 1, 0, 0, 0, -1);

    // Log wrap, then clear empties it
    step(1, 0, 0, 0, 0, -1);
    for (int i = 1; i <= 6; i++) step(0, 0, 1, 32'd96, 32'(i), 0);
    step(0, 0, 0, 0, 0, 3);
    step(0, 1, 0, 0, 0, 3);
    // clear with arm in the same cycle: clear wins
    step(1, 1, 0, 0, 0, -1);

    // Reset mid-run, asserted between edges
    step(1, 0, 0, 0, 0, -1);
    step(0, 0, 1, 32'd96, 32'd11, -1);
    step(0, 0, 1, 32'd96, 32'd12, 0);
    @(negedge clk);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    log_idx = '0;
    compare(snap(2'd0));
    @(posedge clk);
    #3;
    reset = 1'b1;
    idle(3);
    step(1, 0, 0, 0, 0, -1);
    step(0, 0, 1, 32'd96, 32'd13, 0);
    step(0, 1, 0, 0, 0, -1);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1, 2, 3, 4, 5: adr = 32'd96;
        6:                adr = 32'd100;
        7:                adr = 32'd104;
        default:          adr = $urandom & 32'hFFFF_FFFC;
      endcase
      dat = ($urandom_range(0, 3) == 0) ? 32'd7 : 32'($urandom_range(0, 9));
      step(($urandom_range(0, 3) == 0),
           (m_st >= S_PASS) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 2) == 0), adr, dat, -1);
    end

    repeat (3) @(negedge clk);
    #3;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_store_checker.md
Name: dmem_store_checker

Overview:
- Synthesizable on-chip self-check block that sits directly downstream of the MCU core's data-memory write port.
- Taps MemWrite/DataAdr/WriteData in parallel with dmem and judges the store stream as PASS, FAIL or TIMEOUT.
- Keeps a circular log of recent stores for debug readout.
- Gives board bring-up the same verdict as the simulation bench: LEDs or a debug bus replace $display.

Parameters:
- PASS_ADDR, 32'd100, store address that ends the test when paired with PASS_DATA.
- PASS_DATA, 32'd7, data value required at PASS_ADDR.
- ALLOW_ADDR, 32'd96, only other legal store address while the test runs.
- TIMEOUT_CYCLES, 4096, cycles in ARMED without a verdict before TIMEOUT.
- CNT_W, 16, width of the cycle and store counters.
- LOG_AW, 3, log depth is 2^LOG_AW entries.

Ports:
- clk  in  1  system clock, same clock as the core and dmem.
- reset  in  1  asynchronous, active-low reset.
- arm  in  1  synchronous start pulse; IDLE→ARMED.
- clear  in  1  synchronous return to IDLE from any state; clears counters and the log.
- MemWrite  in  1  dmem write enable from the core.
- DataAdr  in  32  dmem address from the core.
- WriteData  in  32  dmem write data from the core.
- log_idx  in  LOG_AW  log read index; 0 = most recent store.
- log_addr  out  32  address of the selected log entry.
- log_data  out  32  data of the selected log entry.
- log_count  out  LOG_AW+1  number of valid log entries, saturates at 2^LOG_AW.
- busy  out  1  state == ARMED.
- done  out  1  state is PASS, FAIL or TIMEOUT.
- pass  out  1  state == PASS.
- fail  out  1  state == FAIL.
- timeout  out  1  state == TIMEOUT.
- store_count  out  CNT_W  stores accepted in ARMED; saturating.
- cycle_count  out  CNT_W  cycles spent in ARMED; saturating.
- fail_addr  out  32  DataAdr of the offending store.
- fail_data  out  32  WriteData of the offending store.

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs, counters, log pointer, log_count, fail_addr and fail_data are 0.
- Log RAM contents need no reset; log_count=0 marks them invalid.
- States: IDLE, ARMED, PASS, FAIL, TIMEOUT (encoding in the package).
- IDLE: arm=1 → ARMED. Stores are ignored. cycle_count and store_count stay 0.
- ARMED, per rising clk edge, evaluated in this order:
  - If MemWrite=1, log {DataAdr, WriteData} and increment store_count (saturating). Then:
    - DataAdr==PASS_ADDR && WriteData==PASS_DATA → PASS.
    - else DataAdr!=ALLOW_ADDR → FAIL, capturing fail_addr/fail_data.
    - else stay in ARMED.
  - PASS_ADDR with wrong data is a FAIL (address is not ALLOW_ADDR).
  - If no transition was taken and cycle_count == TIMEOUT_CYCLES-1 → TIMEOUT.
  - A store in the same cycle wins over timeout.
  - cycle_count increments every ARMED cycle, saturating at all-ones.
- PASS/FAIL/TIMEOUT are sticky.
  - Further stores are neither logged nor counted; counters freeze.
  - arm is ignored. Only clear or reset leaves these states.
- clear has priority over arm and over the store evaluation in the same cycle.
  - clear → IDLE; counters, log_count, fail_addr and fail_data go to 0.
- Latency: status outputs are registered and visible one cycle after the sampling edge. This is the same edge on which dmem commits the write.
- Log: circular write pointer wraps modulo 2^LOG_AW; the oldest entry is overwritten.
  - Read is combinational from log_idx: entry = wr_ptr-1-log_idx (mod depth).
  - log_idx >= log_count returns 0 on both outputs.
- Inputs from the core are synchronous to clk. No synchronizers; arm and clear are also same-domain.

Decomposition:
- Package dmem_chk_pkg holds:
  - the state enum localparams;
  - default PASS_ADDR, PASS_DATA and ALLOW_ADDR constants;
  - the log entry width, 64.
- One sub-module, dmem_store_log: 2^LOG_AW x 64 circular buffer with write pointer, saturating count, clear and indexed newest-first read.
- FSM and counters stay in the top of the block.

Test Plan:
- Pass flow: reset, arm, stores @96=5, @96=3, @100=7 → pass=1, done=1, store_count=3; log_idx0 gives 100/7, log_idx2 gives 96/5.
- Illegal address: arm, store @96=1, then @104=9 → fail=1, fail_addr=104, fail_data=9, store_count=2. A later store @100=7 leaves fail=1 and store_count=2.
- Wrong data: arm, store @100=8 → fail=1, fail_addr=100, fail_data=8.
- Timeout: TIMEOUT_CYCLES=16, arm, no stores → timeout=1 exactly 16 cycles after arm, cycle_count=16. Store @100=7 on cycle 16 instead → pass=1, timeout=0.
- Log wrap: LOG_AW=2, arm, 6 stores @96 with data 1..6 → log_count=4, log_idx0=6, log_idx3=3, log_idx3 after clear=0.
- Reset mid-run: arm, 2 stores @96, assert reset asynchronously between edges → all outputs 0 immediately. After release, busy=0 until arm.
